// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-master memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_BUSY  = 1'b1;

  localparam logic ARB_M_CPU = 1'b0;
  localparam logic ARB_M_AUX = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/arb_watchdog.sv
// Counts busy cycles without a downstream ready and flags the cycle that must time out.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 11
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  input  logic hit_ready,
  output logic expired
);

  localparam bit              WD_EN     = (TIMEOUT_CYCLES != 0);
  localparam int unsigned     WD_LAST_I = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_W-1:0] WD_LAST   = TO_W'(WD_LAST_I);

  logic [TO_W-1:0] wd_q;

  // Saturates at the last count so a held stall keeps reporting expiry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q <= '0;
    end else if (clear) begin
      wd_q <= '0;
    end else if (WD_EN && run && !hit_ready && (wd_q != WD_LAST)) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign expired = WD_EN && run && !hit_ready && (wd_q == WD_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory port between the CPU (master 0) and an auxiliary master (1).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_FIXED     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 11
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m1_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic [3:0]  m1_wstrb,
  output logic        m0_ready,
  output logic        m1_ready,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_fault,
  output logic        m1_fault,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant
);

  logic     state_q, state_d;
  logic     grant_q, grant_d;
  logic     last_grant_q, last_grant_d;
  logic     pick;
  logic     is_busy;
  logic     sel_valid;
  logic     expired;
  mem_req_t m0_req, m1_req, sel_req;

  assign m0_req    = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign m1_req    = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign sel_req   = (grant_q == ARB_M_AUX) ? m1_req : m0_req;
  assign sel_valid = (grant_q == ARB_M_AUX) ? m1_valid : m0_valid;
  assign is_busy   = (state_q == ARB_BUSY);
  assign busy      = is_busy;
  assign grant     = grant_q;

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_watchdog (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (!is_busy),
    .run       (is_busy && sel_valid),
    .hit_ready (mem_ready),
    .expired   (expired)
  );

  always_comb begin
    if (m0_valid && m1_valid) begin
      pick = (PRIO_FIXED != 0) ? ARB_M_CPU : ~last_grant_q;
    end else begin
      pick = m1_valid ? ARB_M_AUX : ARB_M_CPU;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (state_q == ARB_IDLE) begin
      if (m0_valid || m1_valid) begin
        state_d      = ARB_BUSY;
        grant_d      = pick;
        last_grant_d = pick;
      end
    end else if (mem_ready || expired || !sel_valid) begin
      // Completion, timeout, or the master withdrew its request.
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      grant_q      <= ARB_M_CPU;
      last_grant_q <= ARB_M_AUX;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_fault  = 1'b0;
    m1_fault  = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (is_busy) begin
      mem_valid = sel_valid && !expired;
      mem_addr  = sel_req.addr;
      mem_wdata = sel_req.wdata;
      mem_wstrb = sel_req.wstrb;
      m0_ready  = (mem_ready || expired) && (grant_q == ARB_M_CPU);
      m1_ready  = (mem_ready || expired) && (grant_q == ARB_M_AUX);
      m0_fault  = expired && (grant_q == ARB_M_CPU);
      m1_fault  = expired && (grant_q == ARB_M_AUX);
      m0_rdata  = m0_fault ? 32'h0 : mem_rdata;
      m1_rdata  = m1_fault ? 32'h0 : mem_rdata;
    end
  end

endmodule
